mem_bus_arbiter: RTL and testbench

Shares the single external memory port between the CPU's instruction-read, data-read and data-write request channels and a debug-monitor access port. It sits between `cpu_top` and the memory/bus controller, replacing the direct fan-in of `i_read_*`, `d_read_*` and `d_write_*`. It serializes transactions, arbitrates between the CPU and the monitor, and returns completion pulses and read data to the requester. A timeout counter prevents a lost acknowledge from hanging the CPU state machine.

---
 rtl/mem_bus_arbiter.sv | 186 ++++++++++++++++++
 tb/tb_mem_bus_arbiter.sv | 392 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_bus_arbiter.sv
// rtl/mem_bus_arbiter.sv - arbitrates CPU i-read/d-read/d-write and monitor onto one memory port
module mem_bus_arbiter #(
    parameter int TIMEOUT_CYC = 1023
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_read_req,
    input  logic        i_read_w,
    input  logic        i_read_hw,
    input  logic [31:0] i_read_adr,
    input  logic        d_read_req,
    input  logic        d_read_w,
    input  logic        d_read_hw,
    input  logic [31:0] d_read_adr,
    input  logic        d_write_req,
    input  logic        d_write_w,
    input  logic        d_write_hw,
    input  logic [31:0] d_write_adr,
    input  logic [31:0] d_write_data,
    output logic        read_valid,
    output logic [31:0] read_data,
    output logic        write_finish,
    input  logic        mon_req,
    input  logic        mon_we,
    input  logic [31:0] mon_adr,
    input  logic [31:0] mon_wdata,
    output logic        mon_ack,
    output logic [31:0] mon_rdata,
    output logic        mem_req,
    output logic        mem_we,
    output logic        mem_w,
    output logic        mem_hw,
    output logic [31:0] mem_adr,
    output logic [31:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic        busy,
    output logic        bus_timeout
);

    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
    // Forced completion happens in the TIMEOUT_CYC-th ISSUE cycle (counter starts at 0).
    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYC - 1);
    localparam logic [CNT_W-1:0] TMO_MAX  = CNT_W'(TIMEOUT_CYC);

    typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_DONE} state_t;
    typedef enum logic [1:0] {OWN_IREAD, OWN_DREAD, OWN_DWRITE, OWN_MON} owner_t;

    state_t            state;
    state_t            state_nxt;
    owner_t            owner;
    owner_t            grant_owner;
    logic              last_mon;
    logic [CNT_W-1:0]  tmo_cnt;
    logic              cpu_any;
    logic              grant_any;
    logic              grant_mon;
    logic              tmo_hit;
    logic              finish;

    always_comb begin
        cpu_any   = d_write_req | d_read_req | i_read_req;
        grant_any = cpu_any | mon_req;
        // Monitor wins alone, or on a tie when the CPU group was served last.
        grant_mon = mon_req & (~cpu_any | ~last_mon);
        if (grant_mon) begin
            grant_owner = OWN_MON;
        end else if (d_write_req) begin
            grant_owner = OWN_DWRITE;
        end else if (d_read_req) begin
            grant_owner = OWN_DREAD;
        end else begin
            grant_owner = OWN_IREAD;
        end
        tmo_hit = (tmo_cnt >= TMO_LAST);
        finish  = mem_ack | tmo_hit;

        state_nxt = state;
        case (state)
            ST_IDLE:  if (grant_any) state_nxt = ST_ISSUE;
            ST_ISSUE: if (finish) state_nxt = ST_DONE;
            ST_DONE:  state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            owner        <= OWN_IREAD;
            last_mon     <= 1'b1;
            tmo_cnt      <= '0;
            mem_req      <= 1'b0;
            mem_we       <= 1'b0;
            mem_w        <= 1'b0;
            mem_hw       <= 1'b0;
            mem_adr      <= '0;
            mem_wdata    <= '0;
            read_valid   <= 1'b0;
            read_data    <= '0;
            write_finish <= 1'b0;
            mon_ack      <= 1'b0;
            mon_rdata    <= '0;
            busy         <= 1'b0;
            bus_timeout  <= 1'b0;
        end else begin
            read_valid   <= 1'b0;
            write_finish <= 1'b0;
            mon_ack      <= 1'b0;
            bus_timeout  <= 1'b0;
            busy         <= (state_nxt != ST_IDLE);
            case (state)
                ST_IDLE: begin
                    if (grant_any) begin
                        mem_req  <= 1'b1;
                        owner    <= grant_owner;
                        last_mon <= (grant_owner == OWN_MON);
                        tmo_cnt  <= '0;
                        case (grant_owner)
                            OWN_MON: begin
                                mem_we    <= mon_we;
                                mem_w     <= 1'b1;
                                mem_hw    <= 1'b0;
                                mem_adr   <= mon_adr;
                                mem_wdata <= mon_wdata;
                            end
                            OWN_DWRITE: begin
                                mem_we    <= 1'b1;
                                mem_w     <= d_write_w;
                                mem_hw    <= d_write_hw;
                                mem_adr   <= d_write_adr;
                                mem_wdata <= d_write_data;
                            end
                            OWN_DREAD: begin
                                mem_we    <= 1'b0;
                                mem_w     <= d_read_w;
                                mem_hw    <= d_read_hw;
                                mem_adr   <= d_read_adr;
                                mem_wdata <= '0;
                            end
                            default: begin
                                mem_we    <= 1'b0;
                                mem_w     <= i_read_w;
                                mem_hw    <= i_read_hw;
                                mem_adr   <= i_read_adr;
                                mem_wdata <= '0;
                            end
                        endcase
                    end
                end
                ST_ISSUE: begin
                    if (tmo_cnt != TMO_MAX) begin
                        tmo_cnt <= tmo_cnt + CNT_W'(1);
                    end
                    if (finish) begin
                        mem_req     <= 1'b0;
                        bus_timeout <= ~mem_ack;
                        case (owner)
                            OWN_MON: begin
                                mon_ack <= 1'b1;
                                if (!mem_we) begin
                                    mon_rdata <= mem_ack ? mem_rdata : 32'h0;
                                end
                            end
                            OWN_DWRITE: write_finish <= 1'b1;
                            default: begin
                                read_valid <= 1'b1;
                                read_data  <= mem_ack ? mem_rdata : 32'h0;
                            end
                        endcase
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb/tb_mem_bus_arbiter.sv - self-checking bench for mem_bus_arbiter
module tb_mem_bus_arbiter;

    localparam int TMO = 8;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        i_read_req, i_read_w, i_read_hw;
    logic [31:0] i_read_adr;
    logic        d_read_req, d_read_w, d_read_hw;
    logic [31:0] d_read_adr;
    logic        d_write_req, d_write_w, d_write_hw;
    logic [31:0] d_write_adr, d_write_data;
    logic        read_valid, write_finish;
    logic [31:0] read_data;
    logic        mon_req, mon_we, mon_ack;
    logic [31:0] mon_adr, mon_wdata, mon_rdata;
    logic        mem_req, mem_we, mem_w, mem_hw, mem_ack;
    logic [31:0] mem_adr, mem_wdata, mem_rdata;
    logic        busy, bus_timeout;

    mem_bus_arbiter #(.TIMEOUT_CYC(TMO)) dut (
        .clk(clk), .rst_n(rst_n),
        .i_read_req(i_read_req), .i_read_w(i_read_w), .i_read_hw(i_read_hw), .i_read_adr(i_read_adr),
        .d_read_req(d_read_req), .d_read_w(d_read_w), .d_read_hw(d_read_hw), .d_read_adr(d_read_adr),
        .d_write_req(d_write_req), .d_write_w(d_write_w), .d_write_hw(d_write_hw),
        .d_write_adr(d_write_adr), .d_write_data(d_write_data),
        .read_valid(read_valid), .read_data(read_data), .write_finish(write_finish),
        .mon_req(mon_req), .mon_we(mon_we), .mon_adr(mon_adr), .mon_wdata(mon_wdata),
        .mon_ack(mon_ack), .mon_rdata(mon_rdata),
        .mem_req(mem_req), .mem_we(mem_we), .mem_w(mem_w), .mem_hw(mem_hw),
        .mem_adr(mem_adr), .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .busy(busy), .bus_timeout(bus_timeout)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int cyc = 0;

    typedef struct {
        logic [3:0]  req;    // {d_write, d_read, i_read, mon}
        int          dly;
        logic [31:0] adr;
        logic        we;
        int          kind;   // 0 read_valid, 1 write_finish, 2 mon_ack
    } vec_t;
    vec_t vecs[10];

    // random-test agents: 0 d_write, 1 d_read, 2 i_read, 3 monitor
    bit          act[4];
    logic [31:0] a_adr[4], a_dat[4];
    bit          a_we[4], a_w[4], a_hw[4];
    int          a_next[4], a_done[4];
    int          decide, owner, grant_c, ack_c, pulse_c, win, cpu_pick;
    bit          last_mon, tmo, in_issue, is_pulse;
    logic [31:0] rd;

    task automatic chk(input string name, input logic [31:0] act_v, input logic [31:0] exp_v);
        tests++;
        if (act_v !== exp_v) begin
            fails++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act_v, exp_v, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic clear_inputs();
        {i_read_req, i_read_w, i_read_hw, d_read_req, d_read_w, d_read_hw} = '0;
        {d_write_req, d_write_w, d_write_hw, mon_req, mon_we, mem_ack} = '0;
        i_read_adr = '0; d_read_adr = '0; d_write_adr = '0; d_write_data = '0;
        mon_adr = '0; mon_wdata = '0; mem_rdata = '0;
    endtask

    task automatic set_req(input logic [3:0] m);
        d_write_req = m[3]; d_write_adr = 32'h200; d_write_data = 32'hCAFEBABE;
        d_write_w = 1'b1; d_write_hw = 1'b0;
        d_read_req = m[2]; d_read_adr = 32'h400; d_read_w = 1'b1; d_read_hw = 1'b0;
        i_read_req = m[1]; i_read_adr = 32'h100; i_read_w = 1'b1; i_read_hw = 1'b0;
        mon_req = m[0]; mon_adr = 32'h300; mon_we = 1'b0; mon_wdata = 32'h55AA55AA;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        clear_inputs();
        tick();
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, " mem_req"}, mem_req, 0);
        chk({tag, " mem_we"}, mem_we, 0);
        chk({tag, " mem_w"}, mem_w, 0);
        chk({tag, " mem_hw"}, mem_hw, 0);
        chk({tag, " mem_adr"}, mem_adr, 0);
        chk({tag, " mem_wdata"}, mem_wdata, 0);
        chk({tag, " read_valid"}, read_valid, 0);
        chk({tag, " read_data"}, read_data, 0);
        chk({tag, " write_finish"}, write_finish, 0);
        chk({tag, " mon_ack"}, mon_ack, 0);
        chk({tag, " mon_rdata"}, mon_rdata, 0);
        chk({tag, " busy"}, busy, 0);
        chk({tag, " bus_timeout"}, bus_timeout, 0);
    endtask

    // Called in the first ISSUE cycle; returns in the DONE (pulse) cycle.
    task automatic serve(input string tag, input logic [31:0] exp_adr, input logic exp_we,
                         input int dly, input logic [31:0] rdata, input int kind);
        chk({tag, " mem_req"}, mem_req, 1);
        chk({tag, " mem_adr"}, mem_adr, exp_adr);
        chk({tag, " mem_we"}, mem_we, exp_we);
        for (int i = 0; i < dly; i++) begin
            tick();
            chk({tag, " held mem_adr"}, mem_adr, exp_adr);
        end
        mem_ack = 1'b1;
        mem_rdata = rdata;
        tick();
        mem_ack = 1'b0;
        mem_rdata = $urandom;
        chk({tag, " read_valid"}, read_valid, kind == 0);
        chk({tag, " write_finish"}, write_finish, kind == 1);
        chk({tag, " mon_ack"}, mon_ack, kind == 2);
        chk({tag, " mem_req done"}, mem_req, 0);
        if (kind == 0) chk({tag, " read_data"}, read_data, rdata);
        if (kind == 2 && !exp_we) chk({tag, " mon_rdata"}, mon_rdata, rdata);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{4'b0001, 0, 32'h300, 1'b0, 2};
        vecs[1] = '{4'b0011, 1, 32'h100, 1'b0, 0};
        vecs[2] = '{4'b0111, 2, 32'h300, 1'b0, 2};
        vecs[3] = '{4'b1111, 0, 32'h200, 1'b1, 1};
        vecs[4] = '{4'b0110, 3, 32'h400, 1'b0, 0};
        vecs[5] = '{4'b0011, 0, 32'h300, 1'b0, 2};
        vecs[6] = '{4'b1001, 1, 32'h200, 1'b1, 1};
        vecs[7] = '{4'b1100, 0, 32'h200, 1'b1, 1};
        vecs[8] = '{4'b0001, 2, 32'h300, 1'b0, 2};
        vecs[9] = '{4'b0101, 0, 32'h400, 1'b0, 0};

        rst_n = 1'b0;
        clear_inputs();
        tick();
        chk_all_zero("reset");
        rst_n = 1'b1;
        tick();
        chk_all_zero("post-reset");

        // single i-read, ack in third ISSUE cycle
        set_req(4'b0010);
        tick();
        chk("iread c1 mem_req", mem_req, 1);
        chk("iread c1 mem_adr", mem_adr, 32'h100);
        chk("iread c1 mem_we", mem_we, 0);
        chk("iread c1 busy", busy, 1);
        tick();
        chk("iread c2 mem_req", mem_req, 1);
        chk("iread c2 read_valid", read_valid, 0);
        tick();
        mem_ack = 1'b1;
        mem_rdata = 32'h00000013;
        tick();
        mem_ack = 1'b0;
        chk("iread c4 read_valid", read_valid, 1);
        chk("iread c4 read_data", read_data, 32'h13);
        chk("iread c4 mem_req", mem_req, 0);
        tick();
        set_req(4'b0000);
        chk("iread c5 busy", busy, 0);
        chk("iread c5 read_valid", read_valid, 0);
        chk("iread c5 read_data held", read_data, 32'h13);
        tick();
        chk("iread c6 mem_req", mem_req, 0);

        // CPU-internal priority: d-read before i-read
        set_req(4'b0110);
        tick();
        serve("prio dread", 32'h400, 1'b0, 1, 32'h11112222, 0);
        tick();
        set_req(4'b0010);
        tick();
        serve("prio iread", 32'h100, 1'b0, 0, 32'h33334444, 0);
        tick();
        set_req(4'b0000);
        tick();

        // back-to-back at minimum latency: pulses at cycles 2, 5, 8
        set_req(4'b1110);
        tick();
        chk("b2b mem_wdata", mem_wdata, 32'hCAFEBABE);
        serve("b2b dwrite", 32'h200, 1'b1, 0, 32'h0, 1);
        tick();
        set_req(4'b0110);
        tick();
        serve("b2b dread", 32'h400, 1'b0, 0, 32'hA5A50001, 0);
        tick();
        set_req(4'b0010);
        tick();
        serve("b2b iread", 32'h100, 1'b0, 0, 32'hA5A50002, 0);
        tick();
        set_req(4'b0000);
        tick();
        chk("b2b no extra grant mem_req", mem_req, 0);
        chk("b2b no extra grant busy", busy, 0);

        // round-robin after reset: CPU first, monitor, then CPU again
        do_reset();
        set_req(4'b1001);
        tick();
        chk("rr1 mem_wdata", mem_wdata, 32'hCAFEBABE);
        serve("rr1 dwrite", 32'h200, 1'b1, 1, 32'h0, 1);
        tick();
        set_req(4'b0001);
        tick();
        chk("rr2 mem_w", mem_w, 1);
        chk("rr2 mem_hw", mem_hw, 0);
        serve("rr2 mon", 32'h300, 1'b0, 0, 32'hDEADBEEF, 2);
        tick();
        set_req(4'b0000);
        tick();
        set_req(4'b1001);
        tick();
        serve("rr3 dwrite", 32'h200, 1'b1, 0, 32'h0, 1);
        tick();
        set_req(4'b0001);
        tick();
        serve("rr4 mon", 32'h300, 1'b0, 0, 32'hBEEF0001, 2);
        tick();
        set_req(4'b0000);
        tick();

        // timeout on a monitor read: pulse and bus_timeout at cycle TMO+1
        set_req(4'b0001);
        for (int c = 1; c <= TMO; c++) begin
            tick();
            chk("tmo issue mem_req", mem_req, 1);
            chk("tmo issue mon_ack", mon_ack, 0);
            chk("tmo issue bus_timeout", bus_timeout, 0);
        end
        tick();
        chk("tmo mon_ack", mon_ack, 1);
        chk("tmo bus_timeout", bus_timeout, 1);
        chk("tmo mon_rdata", mon_rdata, 32'h0);
        chk("tmo mem_req", mem_req, 0);
        tick();
        set_req(4'b0000);
        chk("tmo pulse width", bus_timeout, 0);
        chk("tmo busy", busy, 0);
        tick();

        // reset during ISSUE of a d-write
        set_req(4'b1000);
        tick();
        chk("rst-mid grant", mem_req, 1);
        tick();
        rst_n = 1'b0;
        #1;
        chk_all_zero("rst-mid");
        set_req(4'b0000);
        tick();
        rst_n = 1'b1;
        for (int c = 0; c < 3; c++) begin
            tick();
            chk("rst-mid write_finish", write_finish, 0);
            chk("rst-mid busy", busy, 0);
        end
        set_req(4'b0101);
        tick();
        serve("rst-mid tie", 32'h400, 1'b0, 0, 32'h77778888, 0);
        tick();
        set_req(4'b0000);
        tick();

        // table-driven arbitration sequence from reset
        do_reset();
        foreach (vecs[i]) begin
            set_req(vecs[i].req);
            tick();
            serve($sformatf("vec%0d", i), vecs[i].adr, vecs[i].we, vecs[i].dly, $urandom, vecs[i].kind);
            tick();
            set_req(4'b0000);
            chk($sformatf("vec%0d busy", i), busy, 0);
            tick();
        end

        // randomized traffic against a transaction-timeline model
        do_reset();
        decide = cyc;
        owner = -1;
        grant_c = -100; ack_c = -100; pulse_c = -100;
        last_mon = 1'b1;
        tmo = 1'b0;
        for (int k = 0; k < 4; k++) begin
            act[k] = 1'b0;
            a_next[k] = cyc + $urandom_range(0, 3);
            a_done[k] = -100;
        end
        for (int n = 0; n < 2500; n++) begin
            for (int k = 0; k < 4; k++) begin
                if (act[k] && cyc == a_done[k] + 1) begin
                    act[k] = 1'b0;
                    a_next[k] = cyc + $urandom_range(1, 4);
                end
                if (!act[k] && cyc >= a_next[k]) begin
                    act[k] = 1'b1;
                    a_done[k] = -100;
                    a_adr[k] = $urandom;
                    a_dat[k] = $urandom;
                    a_w[k] = 1'($urandom_range(0, 1));
                    a_hw[k] = 1'($urandom_range(0, 1));
                    a_we[k] = (k == 0) ? 1'b1 : (k == 3) ? 1'($urandom_range(0, 1)) : 1'b0;
                end
            end
            if (cyc == decide) begin
                cpu_pick = act[0] ? 0 : act[1] ? 1 : act[2] ? 2 : -1;
                if (cpu_pick >= 0 && act[3]) win = last_mon ? cpu_pick : 3;
                else if (cpu_pick >= 0) win = cpu_pick;
                else if (act[3]) win = 3;
                else win = -1;
                if (win < 0) begin
                    decide = cyc + 1;
                end else begin
                    owner = win;
                    last_mon = (win == 3);
                    grant_c = cyc + 1;
                    rd = $urandom;
                    if ($urandom_range(0, 9) == 0) begin
                        tmo = 1'b1;
                        ack_c = -100;
                        pulse_c = cyc + 1 + TMO;
                    end else begin
                        tmo = 1'b0;
                        ack_c = grant_c + $urandom_range(0, 4);
                        pulse_c = ack_c + 1;
                    end
                    decide = pulse_c + 1;
                    a_done[win] = pulse_c;
                end
            end
            in_issue = (owner >= 0) && cyc >= grant_c && cyc < pulse_c;
            mem_ack = 1'b0;
            mem_rdata = $urandom;
            if (owner >= 0 && cyc == ack_c) begin
                mem_ack = 1'b1;
                mem_rdata = rd;
            end else if (!in_issue && $urandom_range(0, 3) == 0) begin
                mem_ack = 1'b1;
            end
            d_write_req = act[0]; d_write_adr = a_adr[0]; d_write_data = a_dat[0];
            d_write_w = a_w[0]; d_write_hw = a_hw[0];
            d_read_req = act[1]; d_read_adr = a_adr[1]; d_read_w = a_w[1]; d_read_hw = a_hw[1];
            i_read_req = act[2]; i_read_adr = a_adr[2]; i_read_w = a_w[2]; i_read_hw = a_hw[2];
            mon_req = act[3]; mon_adr = a_adr[3]; mon_wdata = a_dat[3]; mon_we = a_we[3];
            tick();
            in_issue = (owner >= 0) && cyc >= grant_c && cyc < pulse_c;
            is_pulse = (owner >= 0) && cyc == pulse_c;
            chk("rnd mem_req", mem_req, in_issue);
            chk("rnd busy", busy, in_issue || is_pulse);
            if (in_issue) begin
                chk("rnd mem_adr", mem_adr, a_adr[owner]);
                chk("rnd mem_we", mem_we, a_we[owner]);
                chk("rnd mem_w", mem_w, (owner == 3) ? 1'b1 : a_w[owner]);
                chk("rnd mem_hw", mem_hw, (owner == 3) ? 1'b0 : a_hw[owner]);
                if (a_we[owner]) chk("rnd mem_wdata", mem_wdata, a_dat[owner]);
            end
            chk("rnd read_valid", read_valid, is_pulse && (owner == 1 || owner == 2));
            chk("rnd write_finish", write_finish, is_pulse && owner == 0);
            chk("rnd mon_ack", mon_ack, is_pulse && owner == 3);
            chk("rnd bus_timeout", bus_timeout, is_pulse && tmo);
            if (is_pulse && (owner == 1 || owner == 2)) chk("rnd read_data", read_data, tmo ? 32'h0 : rd);
            if (is_pulse && owner == 3 && !a_we[3]) chk("rnd mon_rdata", mon_rdata, tmo ? 32'h0 : rd);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
